shift_cmd_queue: RTL and testbench

Command queue and issue controller upstream of the 32-bit variable shift register. It accepts shift commands (direction, amount, fill word) over a valid/ready handshake and buffers them in a small FIFO. It issues at most one command per cycle as a registered, single-cycle enable pulse with stable dir/shift/data to the shifter. It also provides a pause input for flow control and occupancy and idle status.

---
 rtl/shift_cmd_queue.sv | 72 +++++++
 tb/tb_shift_cmd_queue.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_cmd_queue.sv
// Command FIFO and issue stage in front of the variable shifter.
// Zero-shift commands are consumed as bubbles and never pulse en.
module shift_cmd_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     s_dir,
  input  logic [SHW-1:0]           s_shift,
  input  logic [WIDTH-1:0]         s_data,
  input  logic                     pause,
  output logic                     en,
  output logic                     dir,
  output logic [SHW-1:0]           shift,
  output logic [WIDTH-1:0]         data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     idle
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic             dir;
    logic [SHW-1:0]   shift;
    logic [WIDTH-1:0] data;
  } cmd_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wp, rp;
  logic          push, pop;

  // No bypass in either direction: s_ready ignores a same-cycle pop.
  assign s_ready = !clr && (level < LW'(DEPTH));
  assign push    = s_valid && s_ready;
  assign pop     = !pause && (level != '0);
  assign head    = mem[rp];
  assign idle    = (level == '0) && !en;

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= '{dir: s_dir, shift: s_shift, data: s_data};
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
      en    <= 1'b0;
      dir   <= 1'b0;
      shift <= '0;
      data  <= '0;
    end else begin
      // Pointers are AW bits wide, so wrap modulo DEPTH is implicit.
      if (push) wp <= wp + 1'b1;
      level <= level + LW'(push) - LW'(pop);
      if (pop) begin
        rp    <= rp + 1'b1;
        dir   <= head.dir;
        shift <= head.shift;
        data  <= head.data;
        en    <= (head.shift != '0);
      end else begin
        en    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_shift_cmd_queue.sv
// Self-checking bench for shift_cmd_queue: a reference queue model is pushed on
// accepted commands and popped on issue; each scenario task compares inline.
module tb_shift_cmd_queue;
  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  typedef struct packed {
    logic             dir;
    logic [SHW-1:0]   shift;
    logic [WIDTH-1:0] data;
  } cmd_t;

  logic             clk = 1'b0;
  logic             clr, s_valid, s_ready, s_dir, pause, en, dir, idle;
  logic [SHW-1:0]   s_shift, shift;
  logic [WIDTH-1:0] s_data, data;
  logic [2:0]       level;

  int n_chk  = 0;
  int n_pass = 0;

  cmd_t             sb[$];
  logic             exp_en, exp_dir;
  logic [SHW-1:0]   exp_shift;
  logic [WIDTH-1:0] exp_data;

  shift_cmd_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk(clk), .clr(clr), .s_valid(s_valid), .s_ready(s_ready), .s_dir(s_dir),
    .s_shift(s_shift), .s_data(s_data), .pause(pause), .en(en), .dir(dir),
    .shift(shift), .data(data), .level(level), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic d, input logic [SHW-1:0] sh,
                       input logic [WIDTH-1:0] dt);
    s_valid = v; s_dir = d; s_shift = sh; s_data = dt;
  endtask

  // Advance one clock edge and update the reference model with what that edge did.
  task automatic step();
    bit   acc, pp;
    cmd_t c, in;
    in  = '{dir: s_dir, shift: s_shift, data: s_data};
    acc = s_valid && !clr && (sb.size() < DEPTH);
    pp  = !clr && !pause && (sb.size() > 0);
    @(posedge clk); #1;
    if (clr) begin
      sb.delete();
      exp_en = 0; exp_dir = 0; exp_shift = '0; exp_data = '0;
    end else begin
      exp_en = 0;
      if (pp) begin
        c = sb.pop_front();
        exp_en = (c.shift != 0); exp_dir = c.dir; exp_shift = c.shift; exp_data = c.data;
      end
      if (acc) sb.push_back(in);
    end
  endtask

  task automatic test_reset();
    clr = 1; pause = 0;
    drive(1, 1, 5'd9, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if (s_ready !== 1'b0 || level !== 3'd0 || en !== 1'b0 || idle !== 1'b1)
        $display("FAIL reset_hold cyc%0d: s_ready=%b level=%0d en=%b idle=%b want 0/0/0/1",
                 i, s_ready, level, en, idle);
      else n_pass++;
    end
    n_chk++;
    if (dir !== 1'b0 || shift !== 5'd0 || data !== 32'd0)
      $display("FAIL reset_regs: dir=%b shift=%0d data=%h want zeros", dir, shift, data);
    else n_pass++;
    clr = 0; drive(0, 0, 0, 0);
    #1;
    n_chk++;
    if (s_ready !== 1'b1) $display("FAIL reset_release_ready: s_ready=%b want 1", s_ready);
    else n_pass++;
    step();
    n_chk++;
    if (en !== 1'b0 || level !== 3'd0 || idle !== 1'b1)
      $display("FAIL reset_release: en=%b level=%0d idle=%b want 0/0/1", en, level, idle);
    else n_pass++;
  endtask

  task automatic test_single();
    drive(1, 1, 5'd4, 32'hA5A5_0F0F);
    step();
    drive(0, 0, 0, 0);
    n_chk++;
    if (level !== 3'd1 || en !== 1'b0)
      $display("FAIL single_push: level=%0d en=%b want 1/0", level, en);
    else n_pass++;
    step();
    n_chk++;
    if (en !== 1'b1 || dir !== 1'b1 || shift !== 5'd4 || data !== 32'hA5A5_0F0F)
      $display("FAIL single_issue: en=%b dir=%b shift=%0d data=%h want 1/1/4/a5a50f0f",
               en, dir, shift, data);
    else n_pass++;
    step();
    n_chk++;
    if (en !== 1'b0 || level !== 3'd0 || idle !== 1'b1)
      $display("FAIL single_after: en=%b level=%0d idle=%b want 0/0/1", en, level, idle);
    else n_pass++;
  endtask

  task automatic test_fill_drain();
    for (int r = 0; r < 2; r++) begin
      pause = 1;
      for (int i = 1; i <= 5; i++) begin
        drive(1, 1'(i), 5'(i + 4*r), $urandom);
        #1;
        n_chk++;
        if (s_ready !== (i <= DEPTH))
          $display("FAIL fill_ready r%0d i%0d: s_ready=%b want %b", r, i, s_ready, i <= DEPTH);
        else n_pass++;
        step();
      end
      drive(0, 0, 0, 0);
      n_chk++;
      if (level !== 3'd4 || en !== 1'b0)
        $display("FAIL fill_level r%0d: level=%0d en=%b want 4/0", r, level, en);
      else n_pass++;
      pause = 0;
      for (int k = 1; k <= 4; k++) begin
        step();
        n_chk++;
        if (en !== 1'b1 || shift !== 5'(k + 4*r) || dir !== exp_dir || data !== exp_data)
          $display("FAIL drain r%0d k%0d: en=%b shift=%0d dir=%b data=%h want 1/%0d/%b/%h",
                   r, k, en, shift, dir, data, k + 4*r, exp_dir, exp_data);
        else n_pass++;
      end
      step();
      n_chk++;
      if (en !== 1'b0 || level !== 3'd0)
        $display("FAIL drain_end r%0d: en=%b level=%0d want 0/0", r, en, level);
      else n_pass++;
    end
  endtask

  task automatic test_zero_shift();
    logic [SHW-1:0]   sh [3]  = '{5'd3, 5'd0, 5'd7};
    logic [WIDTH-1:0] dw [3]  = '{32'h1111_0003, 32'h2222_B0B0, 32'h3333_0007};
    logic             pat [3] = '{1'b1, 1'b0, 1'b1};
    pause = 0;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1, 0, sh[i], dw[i]); else drive(0, 0, 0, 0);
      step();
      if (i > 0) begin
        n_chk++;
        if (en !== pat[i-1] || shift !== sh[i-1] || data !== dw[i-1])
          $display("FAIL zero_shift i%0d: en=%b shift=%0d data=%h want %b/%0d/%h",
                   i, en, shift, data, pat[i-1], sh[i-1], dw[i-1]);
        else n_pass++;
      end
    end
    step();
    n_chk++;
    if (en !== 1'b0 || shift !== 5'd7 || level !== 3'd0)
      $display("FAIL zero_shift_hold: en=%b shift=%0d level=%0d want 0/7/0", en, shift, level);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    pause = 0;
    for (int i = 0; i < 21; i++) begin
      if (i < 20) drive(1, 1'(i), 5'((i % 31) + 1), 32'hC0DE_0000 + 32'(i));
      else drive(0, 0, 0, 0);
      step();
      n_chk++;
      if ((i < 20 && level !== 3'd1) || (i == 20 && level !== 3'd0) ||
          en !== (i > 0) || (i > 0 && (shift !== 5'(((i-1) % 31) + 1) ||
                                      data !== 32'hC0DE_0000 + 32'(i-1))))
        $display("FAIL back_to_back c%0d: level=%0d en=%b shift=%0d data=%h want en=%b shift=%0d",
                 i, level, en, shift, data, i > 0, ((i-1) % 31) + 1);
      else n_pass++;
    end
    step();
    n_chk++;
    if (en !== 1'b0 || idle !== 1'b1)
      $display("FAIL back_to_back_end: en=%b idle=%b want 0/1", en, idle);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    pause = 1;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 5'(i + 10), 32'hF00D_0000 + 32'(i));
      step();
    end
    drive(0, 0, 0, 0); pause = 0;
    step();
    n_chk++;
    if (en !== 1'b1 || level !== 3'd3)
      $display("FAIL mid_reset_pre: en=%b level=%0d want 1/3", en, level);
    else n_pass++;
    clr = 1;
    drive(1, 1, 5'd2, 32'h1234_5678);
    step();
    n_chk++;
    if (level !== 3'd0 || en !== 1'b0 || dir !== 1'b0 || shift !== 5'd0 || data !== 32'd0 ||
        s_ready !== 1'b0)
      $display("FAIL mid_reset: level=%0d en=%b dir=%b shift=%0d data=%h s_ready=%b want zeros",
               level, en, dir, shift, data, s_ready);
    else n_pass++;
    clr = 0; drive(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      n_chk++;
      if (en !== 1'b0 || level !== 3'd0)
        $display("FAIL mid_reset_after c%0d: en=%b level=%0d want 0/0", i, en, level);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      pause = ($urandom_range(0, 3) == 0);
      drive(1'($urandom_range(0, 2) != 0), 1'($urandom), 5'($urandom), $urandom);
      #1;
      n_chk++;
      if (s_ready !== (sb.size() < DEPTH))
        $display("FAIL rand_ready c%0d: s_ready=%b want %b", i, s_ready, sb.size() < DEPTH);
      else n_pass++;
      step();
      n_chk++;
      if (en !== exp_en || dir !== exp_dir || shift !== exp_shift || data !== exp_data ||
          level !== 3'(sb.size()) || idle !== (sb.size() == 0 && !exp_en))
        $display("FAIL rand c%0d: en=%b dir=%b sh=%0d data=%h lvl=%0d idle=%b want %b/%b/%0d/%h/%0d",
                 i, en, dir, shift, data, level, idle, exp_en, exp_dir, exp_shift, exp_data,
                 sb.size());
      else n_pass++;
    end
  endtask

  initial begin
    clr = 1; pause = 0; drive(0, 0, 0, 0);
    test_reset();
    test_single();
    test_fill_drain();
    test_zero_shift();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
